// File: rtl/bram_request_responder_pkg.sv
// Shared widths, FSM state type and request record for the BRAM/SPRAM request responder.
// Used by the interface, the EBR block model and the top level.
package mem_ctrl_pkg;

    localparam int DATA_W     = 16;
    localparam int ADDR_W     = 8;
    localparam int BRAM_DEPTH = 256;
    // Block selects are carried zero-extended to this width inside the request record.
    localparam int SEL_W_MAX  = 8;

    typedef enum logic {
        S_INIT,
        S_READY
    } state_t;

    typedef struct packed {
        logic [SEL_W_MAX-1:0] sel;
        logic [ADDR_W-1:0]    rd_addr;
        logic [ADDR_W-1:0]    wr_addr;
        logic [DATA_W-1:0]    data;
        logic                 rd_en;
        logic                 wr_en;
        logic                 spram;
    } req_t;

    function automatic logic sel_in_range(input logic [SEL_W_MAX-1:0] sel, input int num_bram);
        return 32'(sel) < 32'(num_bram);
    endfunction

endpackage

// File: rtl/bram_request_responder_if.sv
// Client request bus and responder return signals for bram_request_responder.
// master = client side, slave = memory responder side.
interface bram_request_responder_if #(
    parameter int MEM_SELECT_BITS = 4
);
    import mem_ctrl_pkg::*;

    logic [MEM_SELECT_BITS-1:0] mem_select;
    logic [ADDR_W-1:0]          rd_addr;
    logic [ADDR_W-1:0]          wr_addr;
    logic [DATA_W-1:0]          data_in;
    logic                       rd_en;
    logic                       wr_en;
    logic                       bram_or_spram;
    logic [DATA_W-1:0]          mem_data_out;
    logic                       rd_valid;
    logic                       addr_err;
    logic                       init_done;

    modport master (
        output mem_select, rd_addr, wr_addr, data_in, rd_en, wr_en, bram_or_spram,
        input  mem_data_out, rd_valid, addr_err, init_done
    );

    modport slave (
        input  mem_select, rd_addr, wr_addr, data_in, rd_en, wr_en, bram_or_spram,
        output mem_data_out, rd_valid, addr_err, init_done
    );

endinterface

// File: rtl/bram_request_responder_bram_block.sv
// One 256x16 EBR: synchronous write, registered read-first output.
// Contents are never reset, matching the physical block.
module bram_block_256x16
    import mem_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [BRAM_DEPTH];

    // Read and write in the same edge: the non-blocking update leaves the read seeing the old word.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/bram_request_responder.sv
// Memory-side responder: services client requests against NUM_BRAM EBR blocks and one SPRAM window.
// Define MEM_INIT_CLEAR_EN to build the power-up clear of every EBR block (256 cycles in S_INIT).
module bram_request_responder
    import mem_ctrl_pkg::*;
#(
    parameter int MEM_SELECT_BITS = 4,
    parameter int NUM_BRAM        = 16,
    parameter int SPRAM_ADDR_BITS = MEM_SELECT_BITS + 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    bram_request_responder_if.slave bus
);

    req_t                       req;
    state_t                     state;
    logic                       ready;
    logic                       rd_go;
    logic                       wr_go;
    logic                       bram_ok;
    logic                       clearing;

    logic [NUM_BRAM-1:0]        blk_we;
    logic [NUM_BRAM-1:0]        blk_re;
    logic [ADDR_W-1:0]          blk_waddr;
    logic [DATA_W-1:0]          blk_wdata;
    logic [DATA_W-1:0]          blk_rdata [NUM_BRAM];

    logic [SPRAM_ADDR_BITS-1:0] spram_raddr;
    logic [SPRAM_ADDR_BITS-1:0] spram_waddr;
    logic [DATA_W-1:0]          spram_mem [2**SPRAM_ADDR_BITS];
    logic [DATA_W-1:0]          spram_q;

    logic                       vld_p1;
    logic                       err_p1;
    logic                       spram_p1;
    logic [SEL_W_MAX-1:0]       sel_p1;
    logic [DATA_W-1:0]          rd_mux;

    logic [DATA_W-1:0]          mem_data_out_p2;
    logic                       vld_p2;
    logic                       err_p2;
    logic                       init_done_p2;

    always_comb begin
        req.sel     = SEL_W_MAX'(bus.mem_select);
        req.rd_addr = bus.rd_addr;
        req.wr_addr = bus.wr_addr;
        req.data    = bus.data_in;
        req.rd_en   = bus.rd_en;
        req.wr_en   = bus.wr_en;
        req.spram   = bus.bram_or_spram;
    end

    assign ready   = (state == S_READY);
    assign rd_go   = ready && req.rd_en;
    assign wr_go   = ready && req.wr_en;
    assign bram_ok = sel_in_range(req.sel, NUM_BRAM);

`ifdef MEM_INIT_CLEAR_EN
    logic [ADDR_W-1:0] clear_cnt;

    assign clearing  = (state == S_INIT);
    assign blk_waddr = clearing ? clear_cnt : req.wr_addr;
`else
    assign clearing  = 1'b0;
    assign blk_waddr = req.wr_addr;
`endif
    assign blk_wdata = clearing ? '0 : req.data;

    // Init FSM; S_READY is terminal until the next reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_INIT;
            init_done_p2 <= 1'b0;
`ifdef MEM_INIT_CLEAR_EN
            clear_cnt    <= '0;
`endif
        end else begin
            case (state)
                S_INIT: begin
`ifdef MEM_INIT_CLEAR_EN
                    clear_cnt <= clear_cnt + 1'b1;
                    if (clear_cnt == ADDR_W'(BRAM_DEPTH - 1)) begin
                        state        <= S_READY;
                        init_done_p2 <= 1'b1;
                    end
`else
                    state        <= S_READY;
                    init_done_p2 <= 1'b1;
`endif
                end
                default: begin
                    state <= S_READY;
                end
            endcase
        end
    end

    // While clearing, every block is written in parallel at clear_cnt.
    for (genvar i = 0; i < NUM_BRAM; i++) begin : g_bram
        assign blk_we[i] = clearing || (wr_go && !req.spram && (req.sel == SEL_W_MAX'(i)));
        assign blk_re[i] = rd_go && !req.spram && (req.sel == SEL_W_MAX'(i));

        bram_block_256x16 u_bram (
            .clk   (clk),
            .we    (blk_we[i]),
            .waddr (blk_waddr),
            .wdata (blk_wdata),
            .re    (blk_re[i]),
            .raddr (req.rd_addr),
            .rdata (blk_rdata[i])
        );
    end

    assign spram_raddr = SPRAM_ADDR_BITS'({bus.mem_select, req.rd_addr});
    assign spram_waddr = SPRAM_ADDR_BITS'({bus.mem_select, req.wr_addr});

    always_ff @(posedge clk) begin
        if (wr_go && req.spram) begin
            spram_mem[spram_waddr] <= req.data;
        end
        if (rd_go && req.spram) begin
            spram_q <= spram_mem[spram_raddr];
        end
    end

    // ---- stage p1: request sampled, memories reading ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1   <= 1'b0;
            err_p1   <= 1'b0;
            spram_p1 <= 1'b0;
            sel_p1   <= '0;
        end else begin
            vld_p1   <= rd_go;
            err_p1   <= (rd_go || wr_go) && !req.spram && !bram_ok;
            spram_p1 <= req.spram;
            sel_p1   <= req.sel;
        end
    end

    // An out-of-range select matches no block and falls through to zero.
    always_comb begin
        rd_mux = '0;
        if (spram_p1) begin
            rd_mux = spram_q;
        end else begin
            for (int i = 0; i < NUM_BRAM; i++) begin
                if (sel_p1 == SEL_W_MAX'(i)) begin
                    rd_mux = blk_rdata[i];
                end
            end
        end
    end

    // ---- stage p2: registered outputs ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_data_out_p2 <= '0;
            vld_p2          <= 1'b0;
            err_p2          <= 1'b0;
        end else begin
            vld_p2 <= vld_p1;
            err_p2 <= err_p1;
            if (vld_p1) begin
                mem_data_out_p2 <= rd_mux;
            end
        end
    end

    assign bus.mem_data_out = mem_data_out_p2;
    assign bus.rd_valid     = vld_p2;
    assign bus.addr_err     = err_p2;
    assign bus.init_done    = init_done_p2;

endmodule
